// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN for two's complement operands and product (default: unsigned).
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_mult
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mult_q, mult_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   op1_mag;
  logic [WIDTH-1:0]   op2_mag;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes are taken as unsigned, so the most negative value maps to 2^(W-1).
  always_comb begin
    op1_mag = i_op1[WIDTH-1] ? (~i_op1 + WIDTH'(1)) : i_op1;
    op2_mag = i_op2[WIDTH-1] ? (~i_op2 + WIDTH'(1)) : i_op2;
    sign_d  = sign_q;
    if (state_q == IDLE && i_valid) begin
      sign_d = i_op1[WIDTH-1] ^ i_op2[WIDTH-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end

  assign product = sign_q ? ('0 - acc_sum) : acc_sum;
`else
  assign op1_mag = i_op1;
  assign op2_mag = i_op2;
  assign product = acc_sum;
`endif

  assign partial = op2_q[cnt_q] ? ({{WIDTH{1'b0}}, op1_q} << cnt_q) : '0;
  assign acc_sum = acc_q + partial;

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mult_d  = mult_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op1_d   = op1_mag;
          op2_d   = op2_mag;
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        // The last bit's partial product is folded straight into the output register.
        if (cnt_q == LAST_CNT) begin
          mult_d  = product;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mult_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mult_q  <= mult_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_mult  = mult_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: 4-bit table vectors, corner sequences, 16-bit random.
// Expected values follow MULT_SIGNED_EN when it is defined for the build.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;

  logic        valid4, ready_in4, ready4, out_valid4;
  logic [3:0]  op1_4, op2_4;
  logic [7:0]  mult4;

  logic        valid16, ready_in16, ready16, out_valid16;
  logic [15:0] op1_16, op2_16;
  logic [31:0] mult16;

  int          tests_run;
  int          tests_failed;
  logic [31:0] sb_q[$];
  logic [31:0] prev4;
  logic [31:0] prev16;

  typedef struct {
    logic [3:0] op1;
    logic [3:0] op2;
    logic [7:0] exp;
    int         hold;
    bit         noise;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier #(.WIDTH(4)) dut4 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid4),
    .o_ready(ready4),
    .i_op1  (op1_4),
    .i_op2  (op2_4),
    .o_valid(out_valid4),
    .i_ready(ready_in4),
    .o_mult (mult4)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid16),
    .o_ready(ready16),
    .i_op1  (op1_16),
    .i_op2  (op2_16),
    .o_valid(out_valid16),
    .i_ready(ready_in16),
    .o_mult (mult16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit big, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (big) begin
      valid16 = v;
      op1_16  = a;
      op2_16  = b;
    end else begin
      valid4 = v;
      op1_4  = a[3:0];
      op2_4  = b[3:0];
    end
  endtask

  task automatic set_ready(input bit big, input logic r);
    if (big) ready_in16 = r;
    else     ready_in4  = r;
  endtask

  function automatic logic [31:0] cur_mult(input bit big);
    return big ? mult16 : {24'b0, mult4};
  endfunction

  function automatic logic cur_valid(input bit big);
    return big ? out_valid16 : out_valid4;
  endfunction

  function automatic logic cur_ready(input bit big);
    return big ? ready16 : ready4;
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [31:0] p;
    p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    return p;
`else
    return {16'b0, a} * {16'b0, b};
`endif
  endfunction

  // One full transaction, called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic apply_stimulus(input bit big, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] exp, input int hold, input bit noise);
    int          cyc;
    int          lat;
    logic [31:0] prev;
    logic [31:0] want;
    prev = big ? prev16 : prev4;
    lat  = big ? 16 : 4;
    check_output("ready_in_idle", {31'b0, cur_ready(big)}, 32'd1);
    set_ready(big, (hold == 0));
    drive(big, 1'b1, a, b);
    sb_q.push_back(exp);
    @(negedge clk);
    drive(big, 1'b0, 16'h0, 16'h0);
    cyc = 0;
    while (cur_valid(big) !== 1'b1 && cyc < 40) begin
      check_output("ready_low_calc", {31'b0, cur_ready(big)}, 32'd0);
      check_output("mult_kept_calc", cur_mult(big), prev);
      if (noise) drive(big, 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      cyc++;
    end
    check_output("latency", cyc, lat);
    want = sb_q.pop_front();
    check_output("product", cur_mult(big), want);
    for (int i = 0; i < hold; i++) begin
      if (noise) drive(big, 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      check_output("hold_valid", {31'b0, cur_valid(big)}, 32'd1);
      check_output("hold_ready", {31'b0, cur_ready(big)}, 32'd0);
      check_output("hold_mult", cur_mult(big), want);
    end
    drive(big, 1'b0, 16'h0, 16'h0);
    set_ready(big, 1'b1);
    @(negedge clk);
    check_output("valid_cleared", {31'b0, cur_valid(big)}, 32'd0);
    check_output("back_to_idle", {31'b0, cur_ready(big)}, 32'd1);
    check_output("mult_kept_idle", cur_mult(big), want);
    if (big) prev16 = want;
    else     prev4  = want;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    prev4        = 32'h0;
    prev16       = 32'h0;
    rst_n        = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 16'h0, 16'h0);
    ready_in4    = 1'b0;
    ready_in16   = 1'b0;

`ifdef MULT_SIGNED_EN
    vecs[0] = '{4'd3, 4'd5, 8'h0F, 0,  1'b0};
    vecs[1] = '{4'hF, 4'hF, 8'h01, 0,  1'b0};
    vecs[2] = '{4'h0, 4'h9, 8'h00, 0,  1'b0};
    vecs[3] = '{4'hD, 4'd5, 8'hF1, 10, 1'b1};
    vecs[4] = '{4'h8, 4'h8, 8'h40, 0,  1'b0};
    vecs[5] = '{4'd7, 4'hF, 8'hF9, 2,  1'b0};
    vecs[6] = '{4'h8, 4'd1, 8'hF8, 0,  1'b0};
    vecs[7] = '{4'd7, 4'd7, 8'h31, 0,  1'b0};
`else
    vecs[0] = '{4'd3, 4'd5, 8'h0F, 0,  1'b0};
    vecs[1] = '{4'hF, 4'hF, 8'hE1, 0,  1'b0};
    vecs[2] = '{4'h0, 4'h9, 8'h00, 0,  1'b0};
    vecs[3] = '{4'hF, 4'hF, 8'hE1, 10, 1'b1};
    vecs[4] = '{4'h8, 4'h8, 8'h40, 0,  1'b0};
    vecs[5] = '{4'hD, 4'd5, 8'h41, 2,  1'b0};
    vecs[6] = '{4'd7, 4'hF, 8'h69, 0,  1'b0};
    vecs[7] = '{4'hA, 4'h1, 8'h0A, 0,  1'b0};
`endif

    #12;
    check_output("rst_ready4", {31'b0, ready4}, 32'd1);
    check_output("rst_valid4", {31'b0, out_valid4}, 32'd0);
    check_output("rst_mult4", {24'b0, mult4}, 32'd0);
    check_output("rst_ready16", {31'b0, ready16}, 32'd1);
    check_output("rst_mult16", mult16, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, {12'b0, vecs[i].op1}, {12'b0, vecs[i].op2},
                     {24'b0, vecs[i].exp}, vecs[i].hold, vecs[i].noise);
    end

    // Abort in the second CALC cycle: outputs return to reset values immediately.
    ready_in4 = 1'b1;
    drive(1'b0, 1'b1, 16'h5, 16'h6);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", {31'b0, out_valid4}, 32'd0);
    check_output("abort_mult", {24'b0, mult4}, 32'd0);
    check_output("abort_ready", {31'b0, ready4}, 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    prev4  = 32'h0;
    prev16 = 32'h0;
    @(negedge clk);
    apply_stimulus(1'b0, 16'd2, 16'd7, 32'd14, 0, 1'b0);

    apply_stimulus(1'b1, 16'hFFFF, 16'hFFFF, model16(16'hFFFF, 16'hFFFF), 0, 1'b0);
    apply_stimulus(1'b1, 16'h8000, 16'h8000, model16(16'h8000, 16'h8000), 1, 1'b0);
    apply_stimulus(1'b1, 16'h0000, 16'h1234, model16(16'h0000, 16'h1234), 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      apply_stimulus(1'b1, a, b, model16(a, b), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
